// File: rtl/ram_request_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_request_arbiter_pkg
//   Shared types for the RAM request arbiter:
//     word_t      - 32-bit machine word
//     ramstate_t  - RAM handshake state (FREE, BUSY, ACCESS, ERROR)
//     arb_state_t - arbiter FSM state (ARB_IDLE, ARB_BUSY); prefixed so the
//                   literals do not collide with ramstate_t's BUSY
//   plus the default data-class mask and a lowest-set-bit helper used to
//   break ties among starved requesters.
// ---------------------------------------------------------------------------
package ram_request_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Odd indices are data caches (dcache0, dcache1, ...).
  localparam logic [7:0] DEFAULT_DATA_MASK = 8'b1010_1010;

  // Index of the lowest set bit of mask (0 when mask is empty).
  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_set = 3'(i);
      end else begin
        lowest_set = lowest_set;
      end
    end
  endfunction

endpackage

// File: rtl/ram_request_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// ram_request_arbiter_rr_pick
//   Round-robin search: returns the first set bit of active at or after ptr,
//   wrapping from N-1 back to 0.
//   Ports:
//     active  in  N   candidate mask
//     ptr     in  W   search start position (must be < N)
//     found   out 1   some bit of active is set
//     idx     out W   winning index (0 when nothing found)
// ---------------------------------------------------------------------------
module ram_request_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] active,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  localparam logic [W:0] N_L = (W + 1)'(N);

  logic [W:0] pos_s;

  // Scan from farthest to nearest offset so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos_s = {1'b0, ptr} + k[W:0];
      if (pos_s >= N_L) begin
        pos_s = pos_s - N_L;
      end else begin
        pos_s = pos_s;
      end
      if (active[pos_s[W-1:0]]) begin
        found = 1'b1;
        idx   = pos_s[W-1:0];
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/ram_request_arbiter.sv
// ---------------------------------------------------------------------------
// ram_request_arbiter
//   Shares one RAM port between NREQ cache requesters. Data-class requesters
//   (DATA_MASK bit set) beat instruction-class requesters; round-robin within
//   each class. A grant is held until RAM reports ACCESS (or the owner drops
//   its request), after which the arbiter spends one IDLE cycle re-arbitrating.
//   Optional feature macro: RAM_ARB_AGE_BOOST_EN - per-requester age counters;
//   a requester aged to AGE_MAX beats both classes (lowest index on ties).
//   Ports:
//     CLK, nRST               clock / async active-low reset
//     req_ren, req_wen        per-requester read / write enable
//     req_addr, req_store     per-requester address / write data (held by
//                             the requester while req_wait=1, not latched)
//     req_wait                combinational stall per requester
//     req_load                ramload broadcast
//     ramaddr, ramstore,
//     ramREN, ramWEN          RAM request, driven from the owner while BUSY
//     ramload, ramstate       RAM response
//     grant_vld, grant_id     grant held / current owner
//     ram_err                 sticky ERROR-while-BUSY flag
// ---------------------------------------------------------------------------
module ram_request_arbiter
  import ram_request_arbiter_pkg::*;
#(
  parameter int              NREQ      = 4,
  parameter logic [NREQ-1:0] DATA_MASK = DEFAULT_DATA_MASK[NREQ-1:0],
  parameter int              AGE_MAX   = 15,
  localparam int             IDW       = $clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      req_ren,
  input  logic [NREQ-1:0]      req_wen,
  input  word_t [NREQ-1:0]     req_addr,
  input  word_t [NREQ-1:0]     req_store,
  output logic [NREQ-1:0]      req_wait,
  output word_t                req_load,
  output word_t                ramaddr,
  output word_t                ramstore,
  output logic                 ramREN,
  output logic                 ramWEN,
  input  word_t                ramload,
  input  ramstate_t            ramstate,
  output logic                 grant_vld,
  output logic [IDW-1:0]       grant_id,
  output logic                 ram_err
);

  arb_state_t      state_r;
  logic [IDW-1:0]  owner_r;
  logic [IDW-1:0]  ptr_d_r;
  logic [IDW-1:0]  ptr_i_r;
  logic            ram_err_r;

  logic [NREQ-1:0] active_s;
  logic            pick_d_found_s;
  logic            pick_i_found_s;
  logic [IDW-1:0]  pick_d_idx_s;
  logic [IDW-1:0]  pick_i_idx_s;
  logic            any_act_s;
  logic [IDW-1:0]  winner_s;
  logic            owner_act_s;
  logic            ack_s;
  logic [IDW-1:0]  owner_inc_s;

  assign active_s    = req_ren | req_wen;
  assign any_act_s   = pick_d_found_s | pick_i_found_s;
  assign owner_act_s = active_s[owner_r];
  assign ack_s       = (state_r == ARB_BUSY) & owner_act_s & (ramstate == ACCESS);
  assign owner_inc_s = (owner_r == IDW'(NREQ - 1)) ? '0 : owner_r + IDW'(1);

  assign req_load  = ramload;
  assign grant_vld = (state_r == ARB_BUSY);
  assign grant_id  = owner_r;
  assign ram_err   = ram_err_r;

  ram_request_arbiter_rr_pick #(.N(NREQ), .W(IDW)) u_pick_d (
    .active (active_s & DATA_MASK),
    .ptr    (ptr_d_r),
    .found  (pick_d_found_s),
    .idx    (pick_d_idx_s)
  );

  ram_request_arbiter_rr_pick #(.N(NREQ), .W(IDW)) u_pick_i (
    .active (active_s & ~DATA_MASK),
    .ptr    (ptr_i_r),
    .found  (pick_i_found_s),
    .idx    (pick_i_idx_s)
  );

`ifdef RAM_ARB_AGE_BOOST_EN
  logic [3:0]      age_r [NREQ];
  logic [NREQ-1:0] aged_s;

  // Flag requesters that have waited long enough to override priority.
  always_comb begin
    aged_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      aged_s[i] = active_s[i] & (age_r[i] == 4'(AGE_MAX));
    end
  end

  // Winner: starved requester first, then data class, then instruction class.
  always_comb begin
    if (|aged_s) begin
      winner_s = IDW'(lowest_set(8'(aged_s)));
    end else if (pick_d_found_s) begin
      winner_s = pick_d_idx_s;
    end else begin
      winner_s = pick_i_idx_s;
    end
  end

  // Age counters: count waiting cycles, clear on grant or when idle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREQ; i++) begin
        age_r[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!active_s[i]) begin
          age_r[i] <= 4'd0;
        end else if ((state_r == ARB_IDLE) && (winner_s == IDW'(i))) begin
          age_r[i] <= 4'd0;
        end else if ((state_r == ARB_BUSY) && (owner_r == IDW'(i))) begin
          age_r[i] <= age_r[i];
        end else if (age_r[i] < 4'(AGE_MAX)) begin
          age_r[i] <= age_r[i] + 4'd1;
        end else begin
          age_r[i] <= age_r[i];
        end
      end
    end
  end
`else
  // Winner: data class beats instruction class.
  always_comb begin
    if (pick_d_found_s) begin
      winner_s = pick_d_idx_s;
    end else begin
      winner_s = pick_i_idx_s;
    end
  end
`endif

  // Arbiter FSM: grant in IDLE, hold until ACCESS or abort, rotate on ACCESS.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= ARB_IDLE;
      owner_r   <= '0;
      ptr_d_r   <= '0;
      ptr_i_r   <= '0;
      ram_err_r <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (any_act_s) begin
            owner_r <= winner_s;
            state_r <= ARB_BUSY;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_BUSY: begin
          if (ramstate == ERROR) begin
            ram_err_r <= 1'b1;
          end else begin
            ram_err_r <= ram_err_r;
          end
          // An abort leaves the round-robin pointers untouched.
          if (!owner_act_s) begin
            state_r <= ARB_IDLE;
          end else if (ramstate == ACCESS) begin
            if (DATA_MASK[owner_r]) begin
              ptr_d_r <= owner_inc_s;
            end else begin
              ptr_i_r <= owner_inc_s;
            end
            state_r <= ARB_IDLE;
          end else begin
            state_r <= ARB_BUSY;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  // RAM request follows the owner's live signals; a write wins over a read.
  always_comb begin
    if (state_r == ARB_BUSY) begin
      ramWEN   = req_wen[owner_r];
      ramREN   = req_ren[owner_r] & ~req_wen[owner_r];
      ramaddr  = req_addr[owner_r];
      ramstore = req_store[owner_r];
    end else begin
      ramWEN   = 1'b0;
      ramREN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
    end
  end

  // Every active requester stalls except the owner in its ACCESS cycle.
  always_comb begin
    req_wait = active_s;
    if (ack_s) begin
      req_wait[owner_r] = 1'b0;
    end else begin
      req_wait = active_s;
    end
  end

endmodule
